// File: rtl/sample_in_ball_engine.sv
// ML-DSA SampleInBall: builds the sparse challenge polynomial c from an XOF byte stream.
// Coefficients are stored as 2'b00 = 0, 2'b01 = +1, 2'b11 = -1.
module sample_in_ball_engine #(
  parameter int N          = 256,
  parameter int LOG_N      = 8,
  parameter int CLR_LANES  = 8,
  parameter int SIGN_BYTES = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [6:0]       tau,
  input  logic [7:0]       xof_data,
  input  logic             xof_valid,
  output logic             xof_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] rej_count,
  input  logic [LOG_N-1:0] c_rd_addr,
  output logic [1:0]       c_rd_data
);

  localparam int H_W     = 8 * SIGN_BYTES;
  localparam int TAU_MAX = (N < H_W) ? N : H_W;
  localparam int CLR_CYC = N / CLR_LANES;
  localparam int SB_W    = (SIGN_BYTES > 1) ? $clog2(SIGN_BYTES) : 1;

  localparam logic [7:0]       TAU_MAX_L = 8'(TAU_MAX);
  localparam logic [LOG_N-1:0] I_LAST    = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] CLR_LAST  = LOG_N'(CLR_CYC - 1);
  localparam logic [SB_W-1:0]  SB_LAST   = SB_W'(SIGN_BYTES - 1);
  localparam logic [CNT_W-1:0] REJ_MAX   = {CNT_W{1'b1}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SIGN   = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [6:0]       r_tau;
  logic [LOG_N-1:0] r_i;
  logic [H_W-1:0]   r_h;
  logic [SB_W-1:0]  r_sb;
  logic [LOG_N-1:0] r_clr;
  logic [CNT_W-1:0] r_rej;
  logic             r_done;
  logic             r_err;
  logic             r_valid;
  logic [1:0]       r_c [N];

  logic [2:0]       w_state_nxt;
  logic             w_xfer;
  logic             w_tau_ok;
  logic             w_start_ok;
  logic [LOG_N-1:0] w_j;
  logic             w_j_le_i;
  logic             w_accept;
  logic             w_last_acc;
  logic [LOG_N-1:0] w_i_init;

  assign w_xfer     = xof_valid && xof_ready;
  assign w_tau_ok   = (tau != 7'd0) && ({1'b0, tau} <= TAU_MAX_L);
  assign w_start_ok = (r_state == S_IDLE) && start && w_tau_ok && !abort;
  assign w_j        = xof_data[LOG_N-1:0];
  assign w_j_le_i   = ({1'b0, xof_data} <= 9'(r_i));
  assign w_accept   = w_xfer && (r_state == S_SAMPLE) && w_j_le_i;
  assign w_last_acc = w_accept && (r_i == I_LAST);
  // N - tau taken modulo 2^LOG_N, which is exact because 1 <= tau <= N.
  assign w_i_init   = LOG_N'(N) - LOG_N'(r_tau);

  assign xof_ready  = (r_state == S_SIGN) || (r_state == S_SAMPLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign rej_count  = r_rej;
  assign c_rd_data  = r_valid ? r_c[c_rd_addr] : 2'b00;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = w_start_ok ? S_CLEAR : S_IDLE;
        S_CLEAR:  w_state_nxt = (r_clr == CLR_LAST) ? S_SIGN : S_CLEAR;
        S_SIGN:   w_state_nxt = (w_xfer && (r_sb == SB_LAST)) ? S_SAMPLE : S_SIGN;
        S_SAMPLE: w_state_nxt = w_last_acc ? S_DONE : S_SAMPLE;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tau   <= 7'd0;
      r_i     <= '0;
      r_h     <= '0;
      r_sb    <= '0;
      r_clr   <= '0;
      r_rej   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= !abort && w_last_acc;
      r_err   <= !abort && (r_state == S_IDLE) && start && !w_tau_ok;
      if (abort) begin
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_tau   <= tau;
              r_rej   <= '0;
              r_clr   <= '0;
              r_valid <= 1'b0;
            end
          end
          S_CLEAR: begin
            r_clr <= r_clr + LOG_N'(1);
            r_i   <= w_i_init;
            r_sb  <= '0;
          end
          S_SIGN: begin
            if (w_xfer) begin
              r_h[{r_sb, 3'b000} +: 8] <= xof_data;
              r_sb <= r_sb + SB_W'(1);
            end
          end
          S_SAMPLE: begin
            if (w_accept) begin
              r_h <= r_h >> 1;
              r_i <= r_i + LOG_N'(1);
              if (w_last_acc) begin
                r_valid <= 1'b1;
              end
            end else if (w_xfer && (r_rej != REJ_MAX)) begin
              r_rej <= r_rej + CNT_W'(1);
            end
          end
          S_DONE:  r_valid <= 1'b1;
          default: r_valid <= 1'b0;
        endcase
      end
    end
  end

  // Coefficient array: no reset; c[j]'s write is last so it wins when j == i.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      for (int k = 0; k < CLR_LANES; k++) begin
        r_c[LOG_N'(int'(r_clr) * CLR_LANES + k)] <= 2'b00;
      end
    end else if (w_accept && !abort) begin
      r_c[r_i] <= r_c[w_j];
      r_c[w_j] <= r_h[0] ? 2'b11 : 2'b01;
    end
  end

endmodule
